// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: BHT counter states,
// default table geometry, BTB entry field widths and the sequential PC step.
// Optional statistics counters are enabled in the top with BRU_STATS_EN.
package branch_resolve_unit_pkg;

    // Default table geometry (16 entries, 32-bit PCs)
    localparam int DEF_IDX_BITS = 4;
    localparam int DEF_PC_WIDTH = 32;

    // BTB entry field widths (the tag width follows from PC and index widths)
    localparam int BTB_VALID_BITS = 1;
    localparam int CTR_BITS       = 2;

    // Fall-through distance for a not-taken control instruction
    localparam int PC_INCR = 4;

    // Two-bit saturating branch history states
    typedef enum logic [CTR_BITS-1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_state_e;

    // Next counter value: step towards the observed direction, saturating at the ends
    function automatic logic [CTR_BITS-1:0] bht_next(input logic [CTR_BITS-1:0] ctr,
                                                     input logic                taken);
        logic [CTR_BITS-1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != STRONG_T) nxt = ctr + 2'd1;
        end else begin
            if (ctr != STRONG_NT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_counter_table.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters with one
// combinational read port (IF lookup) and one update port (EX resolve).
// A read of the entry being updated in the same cycle returns the old value.
module bht_counter_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_BITS = DEF_IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0][CTR_BITS-1:0] ctr_all;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            logic [CTR_BITS-1:0] ctr_reg;

            // Each counter resets weakly not-taken and steps only when its index resolves
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ctr_reg <= WEAK_NT;
                end else if (upd_en && (upd_idx == IDX_BITS'(gi))) begin
                    ctr_reg <= bht_next(ctr_reg, upd_taken);
                end
            end

            assign ctr_all[gi] = ctr_reg;
        end
    endgenerate

    assign rd_ctr = ctr_all[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolve unit. Resolves BEQ/BNE/BLT/BGE/JAL/JALR, compares
// with the prediction carried from IF, issues a registered one-cycle redirect
// on mispredict, and owns the BHT/BTB that IF reads for prediction.
// Optional: define BRU_STATS_EN to add saturating branch/mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_BITS = DEF_IDX_BITS,
    parameter int PC_WIDTH = DEF_PC_WIDTH,
    parameter int TAG_BITS = PC_WIDTH - IDX_BITS - 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                if_pred_taken,
    output logic [PC_WIDTH-1:0] if_pred_target,
    input  logic                ex_valid,
    input  logic                ex_stall,
    input  logic                ex_is_branch,
    input  logic                ex_is_jal,
    input  logic                ex_is_jalr,
    input  logic [PC_WIDTH-1:0] ex_pc,
    input  logic [PC_WIDTH-1:0] ex_imm,
    input  logic [31:0]         alu_result,
    input  logic                alu_bcond,
    input  logic                ex_pred_taken,
    input  logic [PC_WIDTH-1:0] ex_pred_target,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Table indexing for the fetch lookup and the resolving instruction
    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0] ex_tag;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[PC_WIDTH-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[PC_WIDTH-1:IDX_BITS+2];

    // Resolve results
    logic                is_ctrl;
    logic                res;
    logic                actual_taken;
    logic [PC_WIDTH-1:0] actual_target;
    logic [PC_WIDTH-1:0] seq_pc;
    logic                mispredict;

    // Decide direction and target; an instruction seen during a redirect is wrong-path
    always_comb begin
        is_ctrl      = ex_is_branch | ex_is_jal | ex_is_jalr;
        res          = ex_valid & ~ex_stall & ~redirect_valid & is_ctrl;
        actual_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & alu_bcond);
        seq_pc       = ex_pc + PC_WIDTH'(PC_INCR);
        if (ex_is_jalr) begin
            actual_target = PC_WIDTH'({alu_result[31:1], 1'b0});
        end else begin
            actual_target = ex_pc + ex_imm;
        end
        mispredict = (actual_taken != ex_pred_taken) ||
                     (actual_taken && (ex_pred_target != actual_target));
    end

    // Branch history counters (updated by conditional branches only)
    logic [CTR_BITS-1:0] if_ctr;

    bht_counter_table #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (if_idx),
        .rd_ctr    (if_ctr),
        .upd_en    (res & ex_is_branch),
        .upd_idx   (ex_idx),
        .upd_taken (actual_taken)
    );

    // Branch target buffer, one register set per entry
    logic [ENTRIES-1:0][BTB_VALID_BITS-1:0] btb_valid_all;
    logic [ENTRIES-1:0][TAG_BITS-1:0]       btb_tag_all;
    logic [ENTRIES-1:0][PC_WIDTH-1:0]       btb_target_all;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_btb
            logic [BTB_VALID_BITS-1:0] valid_reg;
            logic [TAG_BITS-1:0]       tag_reg;
            logic [PC_WIDTH-1:0]       target_reg;

            // Taken control instructions install their target; not-taken leave the entry alone
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg  <= '0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                end else if (res && actual_taken && (ex_idx == IDX_BITS'(gi))) begin
                    valid_reg  <= 1'b1;
                    tag_reg    <= ex_tag;
                    target_reg <= actual_target;
                end
            end

            assign btb_valid_all[gi]  = valid_reg;
            assign btb_tag_all[gi]    = tag_reg;
            assign btb_target_all[gi] = target_reg;
        end
    endgenerate

    // Fetch prediction: BTB hit and counter in a taken state
    logic btb_hit;

    assign btb_hit        = btb_valid_all[if_idx][0] && (btb_tag_all[if_idx] == if_tag);
    assign if_pred_taken  = btb_hit && if_ctr[1];
    assign if_pred_target = btb_target_all[if_idx];

    // One-cycle redirect pulse; the target is held between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= res && mispredict;
            if (res && mispredict) begin
                redirect_pc <= actual_taken ? actual_target : seq_pc;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    // Saturating counts of resolved control instructions and of mispredicts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else if (res) begin
            if (stat_branches_reg != 32'hFFFF_FFFF) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (mispredict && (stat_mispredicts_reg != 32'hFFFF_FFFF)) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

    // Bits that carry no information for this unit (byte offset, JALR LSB, counter LSB)
    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], alu_result[0], if_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic checked against a table-level reference model.
// Define BRU_STATS_EN to also check the statistics counters.
module tb_branch_resolve_unit;

    localparam int K_BUBBLE = 0;
    localparam int K_NONE   = 1;
    localparam int K_BR     = 2;
    localparam int K_JAL    = 3;
    localparam int K_JALR   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, alu_result;
    logic        alu_bcond, ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .alu_result     (alu_result),
        .alu_bcond      (alu_bcond),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: tables indexed by pc[5:2], tag is pc >> 6
    int unsigned m_ctr   [16];
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    bit          m_rv;
    logic [31:0] m_rpc;
    int unsigned m_branches;
    int unsigned m_mispred;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic bit exp_pred(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ctr[i]   = 1;
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        m_rv       = 1'b0;
        m_rpc      = '0;
        m_branches = 0;
        m_mispred  = 0;
    endtask

    // Present one EX-stage instruction for exactly one clock and advance the model
    task automatic run_cycle(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] alu, input bit bcond, input bit pt,
                             input logic [31:0] ptgt, input bit stall);
        bit ctl, res, taken, mis;
        logic [31:0] tgt;
        int i;
        ex_valid       = (kind != K_BUBBLE);
        ex_is_branch   = (kind == K_BR);
        ex_is_jal      = (kind == K_JAL);
        ex_is_jalr     = (kind == K_JALR);
        ex_pc          = pc;
        ex_imm         = imm;
        alu_result     = alu;
        alu_bcond      = bcond;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        ex_stall       = stall;
        ctl   = (kind == K_BR) || (kind == K_JAL) || (kind == K_JALR);
        res   = ctl && !stall && !m_rv;
        taken = (kind == K_JAL) || (kind == K_JALR) || ((kind == K_BR) && bcond);
        tgt   = (kind == K_JALR) ? (alu & 32'hFFFF_FFFE) : (pc + imm);
        mis   = (taken != pt) || (taken && (ptgt != tgt));
        @(posedge clk);
        #1;
        i    = idx_of(pc);
        m_rv = res && mis;
        if (res && mis) m_rpc = taken ? tgt : pc + 32'd4;
        if (res && (kind == K_BR)) begin
            if (bcond && (m_ctr[i] < 3)) m_ctr[i] = m_ctr[i] + 1;
            else if (!bcond && (m_ctr[i] > 0)) m_ctr[i] = m_ctr[i] - 1;
        end
        if (res && taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc >> 6;
            m_tgt[i]   = tgt;
        end
        if (res) m_branches = m_branches + 1;
        if (res && mis) m_mispred = m_mispred + 1;
    endtask

    task automatic bubble();
        run_cycle(K_BUBBLE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_pc = 32'h0;
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_pc = 0; ex_imm = 0; alu_result = 0; alu_bcond = 0; ex_pred_taken = 0; ex_pred_target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_redirect_valid: got %0b expected 0", redirect_valid);
        end
        n_checks++;
        if (redirect_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_redirect_pc: got %h expected 00000000", redirect_pc);
        end
        for (int k = 0; k < 4; k++) begin
            if_pc = 32'h100 + 32'(k * 'h44);
            #1;
            n_checks++;
            if (if_pred_taken !== 1'b0) begin
                n_fail++; $display("FAIL reset_lookup: pc %h got pred %0b expected 0", if_pc, if_pred_taken);
            end
        end
`ifdef BRU_STATS_EN
        n_checks++;
        if ((stat_branches !== 32'h0) || (stat_mispredicts !== 32'h0)) begin
            n_fail++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_directed();
        if_pc = 32'h100;
        #1;
        n_checks++;
        if (if_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL dir_initial_pred: got %0b expected 0", if_pred_taken);
        end
        // BEQ 0x100 taken, predicted not-taken
        run_cycle(K_BR, 32'h100, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        if_pc = 32'h100;
        #1;
        n_checks++;
        if ((redirect_valid !== 1'b1) || (redirect_pc !== 32'h140)) begin
            n_fail++; $display("FAIL dir_beq_redirect: got %0b/%h expected 1/00000140", redirect_valid, redirect_pc);
        end
        n_checks++;
        if ((if_pred_taken !== 1'b1) || (if_pred_target !== 32'h140)) begin
            n_fail++; $display("FAIL dir_beq_tables: got %0b/%h expected 1/00000140", if_pred_taken, if_pred_target);
        end
        $display("txn BEQ 0x100 mispredict -> redirect %0b pc %h", redirect_valid, redirect_pc);
        bubble();
        n_checks++;
        if (redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL dir_pulse_width: got %0b expected 0", redirect_valid);
        end
        // Two correctly predicted taken BEQs: counter saturates at strongly taken
        for (int k = 0; k < 2; k++) begin
            run_cycle(K_BR, 32'h100, 32'h40, 32'h0, 1'b1, 1'b1, 32'h140, 1'b0);
            n_checks++;
            if (redirect_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir_correct_pred: got redirect %0b expected 0", redirect_valid);
            end
            $display("txn BEQ 0x100 predicted taken -> redirect %0b", redirect_valid);
        end
        // One not-taken from saturation still leaves a taken prediction
        run_cycle(K_BR, 32'h100, 32'h40, 32'h0, 1'b0, 1'b1, 32'h140, 1'b0);
        if_pc = 32'h100;
        #1;
        n_checks++;
        if ((redirect_valid !== 1'b1) || (redirect_pc !== 32'h104)) begin
            n_fail++; $display("FAIL dir_nt_redirect: got %0b/%h expected 1/00000104", redirect_valid, redirect_pc);
        end
        n_checks++;
        if (if_pred_taken !== 1'b1) begin
            n_fail++; $display("FAIL dir_saturation: got pred %0b expected 1", if_pred_taken);
        end
        $display("txn BEQ 0x100 not-taken -> redirect pc %h", redirect_pc);
        bubble();
        // BNE at 0x200 not taken, predicted taken to 0x180
        run_cycle(K_BR, 32'h200, 32'hFFFF_FF80, 32'h0, 1'b0, 1'b1, 32'h180, 1'b0);
        if_pc = 32'h100;
        #1;
        n_checks++;
        if ((redirect_valid !== 1'b1) || (redirect_pc !== 32'h204)) begin
            n_fail++; $display("FAIL dir_bne_redirect: got %0b/%h expected 1/00000204", redirect_valid, redirect_pc);
        end
        n_checks++;
        if (if_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL dir_bne_decrement: got pred %0b expected 0", if_pred_taken);
        end
        $display("txn BNE 0x200 -> redirect pc %h", redirect_pc);
        bubble();
        // JALR at 0x300 with a wrong predicted target
        run_cycle(K_JALR, 32'h300, 32'h0, 32'h1235, 1'b0, 1'b1, 32'h1000, 1'b0);
        if_pc = 32'h100;
        #1;
        n_checks++;
        if ((redirect_valid !== 1'b1) || (redirect_pc !== 32'h1234)) begin
            n_fail++; $display("FAIL dir_jalr_redirect: got %0b/%h expected 1/00001234", redirect_valid, redirect_pc);
        end
        n_checks++;
        if (if_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL dir_jalr_btb_replace: pc 100 got pred %0b expected 0", if_pred_taken);
        end
        $display("txn JALR 0x300 -> redirect pc %h", redirect_pc);
        bubble();
        // BEQ at 0x300 taken: BTB hit on 0x300 now with counter 01 -> 10
        run_cycle(K_BR, 32'h300, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        if_pc = 32'h300;
        #1;
        n_checks++;
        if ((if_pred_taken !== 1'b1) || (if_pred_target !== 32'h310)) begin
            n_fail++; $display("FAIL dir_btb_update: got %0b/%h expected 1/00000310", if_pred_taken, if_pred_target);
        end
        bubble();
        $display("test_directed done");
    endtask

    task automatic test_stall();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle(K_BR, 32'h48, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
            if (redirect_valid === 1'b1) pulses++;
            n_checks++;
            if (redirect_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: cycle %0d got redirect %0b expected 0", k, redirect_valid);
            end
        end
        run_cycle(K_BR, 32'h48, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        if (redirect_valid === 1'b1) pulses++;
        n_checks++;
        if ((redirect_valid !== 1'b1) || (redirect_pc !== 32'h68)) begin
            n_fail++; $display("FAIL stall_release: got %0b/%h expected 1/00000068", redirect_valid, redirect_pc);
        end
        // Wrong-path mispredicting branch during the pulse must be ignored
        run_cycle(K_BR, 32'h80, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        if (redirect_valid === 1'b1) pulses++;
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL stall_pulse_count: got %0d expected 1", pulses);
        end
        if_pc = 32'h48;
        #1;
        n_checks++;
        if ((if_pred_taken !== 1'b1) || (if_pred_target !== 32'h68)) begin
            n_fail++; $display("FAIL stall_single_step: got %0b/%h expected 1/00000068", if_pred_taken, if_pred_target);
        end
        if_pc = 32'h80;
        #1;
        n_checks++;
        if (if_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL stall_wrong_path: pc 80 got pred %0b expected 0", if_pred_taken);
        end
        $display("txn stalled BEQ 0x48 -> %0d redirect pulse(s)", pulses);
        bubble();
        $display("test_stall done");
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] pc, imm, alu, ptgt, probe;
        bit bcond, pt, stall;
        int i;
        for (int n = 0; n < 400; n++) begin
            kind  = int'($urandom_range(0, 4));
            pc    = 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
            imm   = ($urandom_range(0, 63) << 2) - 32'd128;
            alu   = $urandom;
            bcond = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                pt   = exp_pred(pc);
                ptgt = m_tgt[idx_of(pc)];
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = pc + imm;
            end
            run_cycle(kind, pc, imm, alu, bcond, pt, ptgt, stall);
            n_checks++;
            if ((redirect_valid !== m_rv) || (redirect_pc !== m_rpc)) begin
                n_fail++; $display("FAIL rand_redirect: txn %0d got %0b/%h expected %0b/%h", n, redirect_valid, redirect_pc, m_rv, m_rpc);
            end
            probe = ($urandom_range(0, 1) == 1) ? pc : 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
            if_pc = probe;
            #1;
            i = idx_of(probe);
            n_checks++;
            if ((if_pred_taken !== exp_pred(probe)) || (exp_pred(probe) && (if_pred_target !== m_tgt[i]))) begin
                n_fail++; $display("FAIL rand_lookup: pc %h got %0b/%h expected %0b/%h", probe, if_pred_taken, if_pred_target, exp_pred(probe), m_tgt[i]);
            end
`ifdef BRU_STATS_EN
            n_checks++;
            if ((stat_branches !== m_branches) || (stat_mispredicts !== m_mispred)) begin
                n_fail++; $display("FAIL rand_stats: got %0d/%0d expected %0d/%0d", stat_branches, stat_mispredicts, m_branches, m_mispred);
            end
`endif
            $display("txn %0d kind %0d pc %h stall %0b -> redirect %0b pc %h", n, kind, pc, stall, redirect_valid, redirect_pc);
        end
        bubble();
        $display("test_random done");
    endtask

    task automatic test_reset_mid_redirect();
        run_cycle(K_JAL, 32'h2040, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (redirect_valid !== 1'b1) begin
            n_fail++; $display("FAIL midreset_setup: got redirect %0b expected 1", redirect_valid);
        end
        ex_valid = 1'b0; ex_is_jal = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ((redirect_valid !== 1'b0) || (redirect_pc !== 32'h0)) begin
            n_fail++; $display("FAIL midreset_async: got %0b/%h expected 0/00000000", redirect_valid, redirect_pc);
        end
        for (int k = 0; k < 4; k++) begin
            if_pc = (k == 0) ? 32'h2040 : (k == 1) ? 32'h100 : (k == 2) ? 32'h48 : 32'h300;
            #1;
            n_checks++;
            if (if_pred_taken !== 1'b0) begin
                n_fail++; $display("FAIL midreset_lookup: pc %h got pred %0b expected 0", if_pc, if_pred_taken);
            end
        end
`ifdef BRU_STATS_EN
        n_checks++;
        if ((stat_branches !== 32'h0) || (stat_mispredicts !== 32'h0)) begin
            n_fail++; $display("FAIL midreset_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        bubble();
        n_checks++;
        if (redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_after: got redirect %0b expected 0", redirect_valid);
        end
        $display("test_reset_mid_redirect done");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid_redirect();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage consumer of the ALU branch condition.
- Decides taken/not-taken for BEQ/BNE/BLT/BGE/JAL/JALR and compares the result against the IF-stage prediction carried down the pipe.
- Issues a registered redirect/flush on mispredict.
- Owns the branch history table (BHT, 2-bit counters) and branch target buffer (BTB) that IF reads for prediction.

Parameters:
- IDX_BITS, 4, log2 of BHT/BTB entries (16); index = pc[IDX_BITS+1:2]
- PC_WIDTH, 32, address width
- TAG_BITS, PC_WIDTH-IDX_BITS-2, BTB tag = pc[PC_WIDTH-1:IDX_BITS+2]

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_pc  in  PC_WIDTH  fetch PC for prediction lookup
- if_pred_taken  out  1  prediction: BTB hit and counter[1]
- if_pred_target  out  PC_WIDTH  BTB target (valid only when if_pred_taken)
- ex_valid  in  1  EX holds a real instruction
- ex_stall  in  1  EX held this cycle; no state update
- ex_is_branch  in  1  conditional branch
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_pc  in  PC_WIDTH  PC of EX instruction
- ex_imm  in  PC_WIDTH  sign-extended immediate
- alu_result  in  32  ALU result (JALR target source)
- alu_bcond  in  1  ALU branch condition
- ex_pred_taken  in  1  prediction carried from IF
- ex_pred_target  in  PC_WIDTH  predicted target carried from IF
- redirect_valid  out  1  registered; IF must load redirect_pc; IF/ID and ID/EX flush
- redirect_pc  out  PC_WIDTH  registered correct next PC

Behaviour:
- Resolve condition: res = ex_valid & !ex_stall & !redirect_valid & (ex_is_branch|ex_is_jal|ex_is_jalr).
  - The instruction in EX during a redirect cycle is wrong-path and is ignored.
- actual_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & alu_bcond).
- actual_target:
  - JALR: {alu_result[31:1],1'b0}
  - otherwise: ex_pc+ex_imm (mod 2^PC_WIDTH; wrap-around ignored)
- Mispredict when (actual_taken != ex_pred_taken) or (actual_taken & ex_pred_target != actual_target).
- Redirect timing:
  - Next clock after a resolving mispredict: redirect_valid=1, redirect_pc = actual_taken ? actual_target : ex_pc+4.
  - Otherwise redirect_valid=0; redirect_pc holds its last value.
  - redirect_valid is a one-cycle pulse; back-to-back pulses are impossible by construction.
- BHT update (on res & ex_is_branch only): taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
- BTB update (on res & actual_taken): entry[idx] <= {valid=1, tag, actual_target}. Not-taken branches leave the BTB untouched.
- Lookup:
  - Combinational from if_pc.
  - hit = valid & tag match.
  - Read of an index written the same cycle returns the old contents (no bypass).
- ex_stall=1: no table update, no redirect generated; the same instruction resolves once when the stall drops.
- Reset (asynchronous, any time, including mid-redirect):
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0; tags/targets = 0.
  - redirect_valid=0, redirect_pc=0.
  - if_pred_taken therefore reads 0 after reset.
- Non-control instructions with ex_valid=1: no effect.

Optional Feature:
BRU_STATS_EN:
- Defined: adds outputs stat_branches[31:0] (count of resolving control instructions) and stat_mispredicts[31:0] (count of mispredicts).
- Both saturate at 32'hFFFF_FFFF, reset to 0, and do not count during ex_stall.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/opcodes include: BHT state constants (STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11), BTB entry field widths, PC increment constant 4.
- One sub-module, bht_counter_table: 2^IDX_BITS saturating 2-bit counters, with one combinational read port, one write/update port, and async reset.
- BTB storage and resolve logic live in the top module.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0. BEQ at 0x100, imm=0x40, alu_bcond=1, pred 0 -> next cycle redirect_valid=1, redirect_pc=0x140; counter[0]=2'b10; BTB[0] valid with target 0x140.
- Repeat BEQ 0x100 taken, predicted correctly (pred_taken=1, target 0x140) -> no redirect; counter reaches 2'b11 and stays 2'b11 after a third taken.
- BNE at 0x200, pred_taken=1 target 0x180, alu_bcond=0 -> redirect_pc=0x204; counter decrements by one.
- JALR at 0x300, alu_result=0x1235, pred target 0x1000 -> redirect_pc=0x1234; BHT unchanged; BTB index 0 (0x300[5:2]) updated.
- Mispredicting BEQ held with ex_stall=1 for 3 cycles, then released -> exactly one redirect pulse, one counter step. The instruction presented in EX during the pulse cycle, itself a mispredict, produces no second pulse.
- Assert reset during a redirect cycle -> redirect_valid drops immediately (async); all lookups miss afterwards. With BRU_STATS_EN, counters read 0.
